uart_rx_ctrl: RTL
=================

Name: uart_rx_ctrl

Overview:
- Receive-side controller wrapped around the UART receiver FSM.
- Synchronises the raw serial pin and generates the 16x oversampling tick from a runtime divisor.
- Buffers completed bytes in a first-word-fall-through FIFO with a host pop handshake, sticky overflow and an idle-line timeout pulse.
- Sits between the pad, the receiver FSM (rx_sync/s_tick out; rx_done_tick/rx_data in) and the host/bus logic.

Parameters:
- ADDR_W, 4, FIFO address width; depth = 2**ADDR_W entries of 8 bits.
- DVSR_W, 11, width of the baud divisor input.
- TIMEOUT_TICKS, 640, s_tick count of line inactivity (about 4 characters at 16x) before idle_timeout fires; must be >= 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rx_pin  in  1  raw asynchronous serial input.
- dvsr  in  DVSR_W  baud divisor; tick period = dvsr+1 clk cycles.
- rx_sync  out  1  two-flop synchronised rx_pin, to receiver FSM.
- s_tick  out  1  one-cycle oversampling tick, to receiver FSM.
- rx_done_tick  in  1  byte-complete strobe from receiver FSM.
- rx_data  in  8  received byte, valid while rx_done_tick=1.
- rd  in  1  host pop request.
- r_data  out  8  FIFO head byte (FWFT), valid when rx_empty=0.
- rx_empty  out  1  FIFO empty.
- rx_full  out  1  FIFO full.
- count  out  ADDR_W+1  number of occupied entries, 0..2**ADDR_W.
- overflow  out  1  sticky: byte dropped because FIFO full.
- clr_ovf  in  1  clears overflow.
- idle_timeout  out  1  one-cycle pulse on line-idle timeout.

Behaviour:
- Reset values:
  - sync flops = 1, so rx_sync = 1 (line idle).
  - baud counter = 0, s_tick = 0.
  - FIFO pointers = 0: count = 0, rx_empty = 1, rx_full = 0, r_data = 0.
  - overflow = 0, timeout counter = 0, timeout disarmed, idle_timeout = 0.
  - Reset mid-frame or with a non-empty FIFO discards all contents; no partial state survives.
- Synchroniser:
  - rx_sync = rx_pin delayed by 2 clk.
  - No filtering.
- Baud generator:
  - Registered counter cnt.
  - s_tick = (cnt == dvsr), combinational from the register.
  - Next cnt = 0 if cnt >= dvsr, else cnt+1.
  - dvsr = 0 gives s_tick every cycle.
  - dvsr lowered below current cnt: counter wraps to 0 next cycle without emitting a tick for that period.
  - Free-running; not gated by FIFO state.
- FIFO write:
  - On rx_done_tick, rx_data is written at wr_ptr if not full, or if full and a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow is set.
- FIFO read:
  - rd with rx_empty = 0 advances rd_ptr.
  - rd while empty is ignored, including a same-cycle write into the empty FIFO; the written byte appears at r_data the next cycle.
- Pointers:
  - ADDR_W+1 bits wide.
  - empty = pointers equal; full = MSBs differ and lower bits equal.
  - Natural wrap-around.
- Simultaneous push and pop with 0 < count < depth: count unchanged, both pointers advance.
- r_data timing: combinational read of mem[rd_ptr]; updates the cycle after a pop.
- overflow:
  - Set by a dropped write, cleared by clr_ovf.
  - A same-cycle drop and clr_ovf leaves overflow = 1 (set wins).
- Timeout FSM states:
  - DISARMED -> ARMED on any accepted or dropped rx_done_tick; timeout counter cleared.
  - ARMED: rx_done_tick clears the counter; otherwise each s_tick increments it.
  - ARMED -> DISARMED when the counter reaches TIMEOUT_TICKS with rx_empty = 0. idle_timeout pulses high for exactly that cycle; counter cleared.
  - ARMED -> DISARMED silently, without a pulse, if the FIFO becomes empty, i.e. the host drained it.
  - At most one pulse per burst; re-armed only by a new byte.
- Latency: rx_done_tick at cycle N gives rx_empty = 0 and valid r_data at cycle N+1.

Test Plan:
- Baud tick: dvsr=3 held -> s_tick high exactly every 4th cycle, first at cycle 3 after reset release; change dvsr to 1 while cnt=2 -> cnt wraps to 0, then ticks every 2 cycles.
- Sync: rx_pin 1->0 at cycle N -> rx_sync low at N+2; reset -> rx_sync=1.
- FIFO order: push 0x11, 0x22, 0x33 (ADDR_W=2) -> count=3; pops return 0x11, 0x22, 0x33; rx_empty=1 after the third pop.
- Full/overflow: push 5 bytes 0xA0..0xA4 into depth 4 -> rx_full=1, overflow=1, 0xA4 lost; push with simultaneous rd while full -> accepted, count stays 4, no overflow set; clr_ovf together with a drop -> overflow remains 1.
- Boundaries: rd on empty FIFO -> no pointer change; push+pop at count=2 -> count stays 2.
- Timeout: TIMEOUT_TICKS=8, dvsr=0, one byte pushed, no rd -> idle_timeout single pulse 8 cycles after rx_done_tick, no second pulse; repeat with rd before expiry -> no pulse.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive-side controller around a UART receiver FSM.
//
// Purpose:
//   - Synchronises the raw serial pin with two flops.
//   - Generates the 16x oversampling tick from a runtime baud divisor.
//   - Buffers received bytes in a first-word-fall-through FIFO with a host pop handshake.
//   - Flags dropped bytes with a sticky overflow bit.
//   - Pulses idle_timeout once when the line goes quiet while unread data is waiting.
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-high reset
//   rx_pin        raw asynchronous serial input
//   dvsr          baud divisor; tick period is dvsr+1 clk cycles
//   rx_sync       synchronised rx_pin, to the receiver FSM
//   s_tick        one-cycle oversampling tick, to the receiver FSM
//   rx_done_tick  byte-complete strobe from the receiver FSM
//   rx_data       received byte, valid while rx_done_tick is high
//   rd            host pop request
//   r_data        FIFO head byte, valid while rx_empty is low
//   rx_empty      FIFO empty
//   rx_full       FIFO full
//   count         number of occupied entries, 0..2**ADDR_W
//   overflow      sticky: a byte was dropped because the FIFO was full
//   clr_ovf       clears overflow
//   idle_timeout  one-cycle pulse on line-idle timeout
module uart_rx_ctrl #(
  parameter int unsigned ADDR_W        = 4,
  parameter int unsigned DVSR_W        = 11,
  parameter int unsigned TIMEOUT_TICKS = 640
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_pin,
  input  logic [DVSR_W-1:0] dvsr,
  output logic              rx_sync,
  output logic              s_tick,
  input  logic              rx_done_tick,
  input  logic [7:0]        rx_data,
  input  logic              rd,
  output logic [7:0]        r_data,
  output logic              rx_empty,
  output logic              rx_full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              clr_ovf,
  output logic              idle_timeout
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  // The counter only ever holds 0..TIMEOUT_TICKS-1; the expiring tick is detected on the last value.
  localparam int unsigned TcntW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
  localparam logic [TcntW-1:0] TcntLast = TcntW'(TIMEOUT_TICKS - 1);
  localparam logic [ADDR_W:0] PtrOne = (ADDR_W + 1)'(1);

  // ---------------------------------------------------------------------------------------------
  // Two-flop synchroniser; flops reset to 1 so the receiver sees an idle line.
  // ---------------------------------------------------------------------------------------------
  logic sync1_q, sync2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_pin;
      sync2_q <= sync1_q;
    end
  end

  assign rx_sync = sync2_q;

  // ---------------------------------------------------------------------------------------------
  // Baud generator. Using >= for the wrap means a divisor lowered below the current count
  // restarts the period at 0 without emitting a tick for the shortened period.
  // ---------------------------------------------------------------------------------------------
  logic [DVSR_W-1:0] cnt_q, cnt_d;

  assign s_tick = (cnt_q == dvsr);

  always_comb begin
    cnt_d = cnt_q + DVSR_W'(1);
    if (cnt_q >= dvsr) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // FWFT FIFO. Pointers carry one extra wrap bit to tell full from empty.
  // ---------------------------------------------------------------------------------------------
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]      mem_q [Depth];
  logic            empty, full;
  logic            do_rd, do_wr, drop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                 (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

  // A pop while full frees the slot in the same cycle, so a concurrent byte is still accepted.
  // A pop while empty is ignored even if a byte is being written at the same time.
  assign do_rd = rd & ~empty;
  assign do_wr = rx_done_tick & (~full | do_rd);
  assign drop  = rx_done_tick & ~do_wr;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is cleared on reset so r_data reads 0 and no stale byte survives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_wr) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= rx_data;
    end
  end

  assign r_data   = mem_q[rd_ptr_q[ADDR_W-1:0]];
  assign rx_empty = empty;
  assign rx_full  = full;
  assign count    = wr_ptr_q - rd_ptr_q;

  // ---------------------------------------------------------------------------------------------
  // Sticky overflow; a drop in the same cycle as clr_ovf keeps the flag set.
  // ---------------------------------------------------------------------------------------------
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow = ovf_q;

  // ---------------------------------------------------------------------------------------------
  // Idle-line timeout. Armed by any incoming byte (accepted or dropped); fires once when
  // TIMEOUT_TICKS oversampling ticks pass without a new byte while data is still unread.
  // Draining the FIFO disarms it silently.
  // ---------------------------------------------------------------------------------------------
  typedef enum logic [0:0] {
    StDisarmed,
    StArmed
  } to_state_e;

  to_state_e        to_state_q, to_state_d;
  logic [TcntW-1:0] tcnt_q, tcnt_d;

  always_comb begin
    to_state_d   = to_state_q;
    tcnt_d       = tcnt_q;
    idle_timeout = 1'b0;
    unique case (to_state_q)
      StDisarmed: begin
        if (rx_done_tick) begin
          to_state_d = StArmed;
          tcnt_d     = '0;
        end
      end
      StArmed: begin
        if (rx_done_tick) begin
          tcnt_d = '0;
        end else if (empty) begin
          to_state_d = StDisarmed;
          tcnt_d     = '0;
        end else if (s_tick) begin
          if (tcnt_q == TcntLast) begin
            // This tick brings the idle count to TIMEOUT_TICKS.
            idle_timeout = 1'b1;
            to_state_d   = StDisarmed;
            tcnt_d       = '0;
          end else begin
            tcnt_d = tcnt_q + TcntW'(1);
          end
        end
      end
      default: begin
        to_state_d = StDisarmed;
        tcnt_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_state_q <= StDisarmed;
      tcnt_q     <= '0;
    end else begin
      to_state_q <= to_state_d;
      tcnt_q     <= tcnt_d;
    end
  end

endmodule
